// File: rtl/axi_4_pkg.sv
// Shared AXI4 definitions for the 512-bit data bus: widths, response and
// burst encodings, slave FSM state enum and the per-channel payload structs.
package axi_4_pkg;

  localparam int unsigned ID_WIDTH       = 4;
  localparam int unsigned ADDR_WIDTH     = 32;
  localparam int unsigned DATA_BUS_WIDTH = 512;
  localparam int unsigned STRB_WIDTH     = DATA_BUS_WIDTH / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  typedef enum logic [3:0] {
    SLAVE_IDLE,
    WAIT_ARVALID,
    DATA_FETCH,
    WAIT_RREADY,
    WAIT_AWVALID_WVALID,
    WAIT_AWVALID,
    WAIT_WVALID,
    DATA_STORE,
    WAIT_BREADY
  } axi_4_slave_states_e;

  typedef struct packed {
    logic [ID_WIDTH-1:0]   axid;
    logic [ADDR_WIDTH-1:0] axaddr;
    logic [7:0]            axlen;
    logic [2:0]            axsize;
    logic [1:0]            axburst;
  } read_write_address_channel_t;

  typedef struct packed {
    logic [ID_WIDTH-1:0]       rid;
    logic [DATA_BUS_WIDTH-1:0] rdata;
    logic [1:0]                rresp;
    logic                      rlast;
  } read_data_channel_t;

  typedef struct packed {
    logic [ID_WIDTH-1:0]       wid;
    logic [DATA_BUS_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0]     wstrb;
    logic                      wlast;
  } write_data_channel_t;

  typedef struct packed {
    logic [ID_WIDTH-1:0] bid;
    logic [1:0]          bresp;
  } write_response_channel_t;

endpackage

// File: rtl/axi_4_slave_mem.sv
// Memory-backed AXI4 slave for the 512-bit bus. One transaction at a time,
// read preferred over write; DEPTH lines of single-port memory.
// Ports:
//   clk, reset          - clock (rising edge), async active-high reset
//   ar_ch/arvalid/arready - read address channel
//   r_ch/rvalid/rready    - read data channel (rid, rdata, rresp, rlast)
//   aw_ch/awvalid/awready - write address channel
//   w_ch/wvalid/wready    - write data channel (wid ignored)
//   b_ch/bvalid/bready    - write response channel
module axi_4_slave_mem
  import axi_4_pkg::*;
#(
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned ADDR_LSB = 6
) (
  input  logic                        clk,
  input  logic                        reset,
  input  read_write_address_channel_t ar_ch,
  input  logic                        arvalid,
  output logic                        arready,
  output read_data_channel_t          r_ch,
  output logic                        rvalid,
  input  logic                        rready,
  input  read_write_address_channel_t aw_ch,
  input  logic                        awvalid,
  output logic                        awready,
  input  write_data_channel_t         w_ch,
  input  logic                        wvalid,
  output logic                        wready,
  output write_response_channel_t     b_ch,
  output logic                        bvalid,
  input  logic                        bready
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned BYTES = DATA_BUS_WIDTH / 8;

  axi_4_slave_states_e state, state_d;
  logic arready_d, wready_d, rvalid_d, bvalid_d;

  logic [ID_WIDTH-1:0]       id_q;
  logic [IDX_W-1:0]          idx_q;
  logic [IDX_W-1:0]          idx_next;
  logic [IDX_W-1:0]          wrap_mask;
  logic [7:0]                len_q;
  logic [7:0]                beat_q;
  logic [1:0]                burst_q;
  logic                      err_q;
  logic                      len_err_q;
  logic [DATA_BUS_WIDTH-1:0] wdata_q;
  logic [BYTES-1:0]          wstrb_q;
  logic                      wlast_q;
  logic                      len_mismatch;

  logic [DATA_BUS_WIDTH-1:0] mem [DEPTH];

  read_write_address_channel_t sel_ch;
  logic ar_hs, aw_hs, w_hs, r_hs, b_hs;

  // wid carries no meaning for this slave
  logic unused_wid;
  assign unused_wid = ^w_ch.wid;

  // awready yields to a simultaneous read request
  assign awready = arready & ~arvalid;

  assign ar_hs = arvalid & arready;
  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;
  assign r_hs  = rvalid & rready;
  assign b_hs  = bvalid & bready;

  assign sel_ch = ar_hs ? ar_ch : aw_ch;

  // wlast must coincide with the last beat declared by axlen
  assign len_mismatch = (beat_q == len_q) != wlast_q;

  // Any request-level condition that makes the whole burst SLVERR
  function automatic logic req_error(input read_write_address_channel_t ch);
    logic bad_size;
    logic bad_burst;
    logic bad_wrap;
    logic bad_addr;
    bad_size  = ch.axsize != 3'(ADDR_LSB);
    bad_burst = ch.axburst == BURST_RSVD;
    bad_wrap  = (ch.axburst == BURST_WRAP) &&
                !(ch.axlen inside {8'd1, 8'd3, 8'd7, 8'd15});
    bad_addr  = (ch.axaddr >> ADDR_LSB) >= ADDR_WIDTH'(DEPTH);
    return bad_size | bad_burst | bad_wrap | bad_addr;
  endfunction

  // Next line index; WRAP keeps the upper bits of the aligned block
  always_comb begin
    wrap_mask = IDX_W'(len_q);
    idx_next  = idx_q;
    case (burst_q)
      BURST_FIXED: idx_next = idx_q;
      BURST_WRAP:  idx_next = (idx_q & ~wrap_mask) | ((idx_q + IDX_W'(1)) & wrap_mask);
      default:     idx_next = idx_q + IDX_W'(1);
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= SLAVE_IDLE;
      arready <= 1'b0;
      wready  <= 1'b0;
      rvalid  <= 1'b0;
      bvalid  <= 1'b0;
    end else begin
      state   <= state_d;
      arready <= arready_d;
      wready  <= wready_d;
      rvalid  <= rvalid_d;
      bvalid  <= bvalid_d;
    end
  end

  // Next state and registered handshake outputs decoded from it
  always_comb begin
    state_d   = state;
    arready_d = 1'b0;
    wready_d  = 1'b0;
    rvalid_d  = 1'b0;
    bvalid_d  = 1'b0;
    case (state)
      SLAVE_IDLE: begin
        if (ar_hs)      state_d = DATA_FETCH;
        else if (aw_hs) state_d = WAIT_WVALID;
      end
      DATA_FETCH:  state_d = WAIT_RREADY;
      WAIT_RREADY: begin
        if (r_hs) state_d = r_ch.rlast ? SLAVE_IDLE : DATA_FETCH;
      end
      WAIT_WVALID: begin
        if (w_hs) state_d = DATA_STORE;
      end
      DATA_STORE:  state_d = wlast_q ? WAIT_BREADY : WAIT_WVALID;
      WAIT_BREADY: begin
        if (b_hs) state_d = SLAVE_IDLE;
      end
      default:     state_d = SLAVE_IDLE;
    endcase
    arready_d = state_d == SLAVE_IDLE;
    wready_d  = state_d == WAIT_WVALID;
    rvalid_d  = state_d == WAIT_RREADY;
    bvalid_d  = state_d == WAIT_BREADY;
  end

  // Request capture, beat tracking and response payloads
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_q      <= '0;
      idx_q     <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      burst_q   <= '0;
      err_q     <= 1'b0;
      len_err_q <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      wlast_q   <= 1'b0;
      r_ch      <= '0;
      b_ch      <= '0;
    end else begin
      case (state)
        SLAVE_IDLE: begin
          if (ar_hs || aw_hs) begin
            id_q      <= sel_ch.axid;
            idx_q     <= sel_ch.axaddr[ADDR_LSB +: IDX_W];
            len_q     <= sel_ch.axlen;
            burst_q   <= sel_ch.axburst;
            err_q     <= req_error(sel_ch);
            beat_q    <= '0;
            len_err_q <= 1'b0;
          end
        end
        DATA_FETCH: begin
          r_ch.rid   <= id_q;
          r_ch.rdata <= err_q ? '0 : mem[idx_q];
          r_ch.rresp <= err_q ? RESP_SLVERR : RESP_OKAY;
          r_ch.rlast <= beat_q == len_q;
        end
        WAIT_RREADY: begin
          if (r_hs && !r_ch.rlast) begin
            beat_q <= beat_q + 8'd1;
            idx_q  <= idx_next;
          end
        end
        WAIT_WVALID: begin
          if (w_hs) begin
            wdata_q <= w_ch.wdata;
            wstrb_q <= w_ch.wstrb;
            wlast_q <= w_ch.wlast;
          end
        end
        DATA_STORE: begin
          beat_q <= beat_q + 8'd1;
          idx_q  <= idx_next;
          if (len_mismatch) len_err_q <= 1'b1;
          if (wlast_q) begin
            b_ch.bid   <= id_q;
            b_ch.bresp <= (err_q || len_err_q || len_mismatch) ? RESP_SLVERR : RESP_OKAY;
          end
        end
        default: ;
      endcase
    end
  end

  // Byte-lane write; contents survive reset
  always_ff @(posedge clk) begin
    if (state == DATA_STORE && !err_q) begin
      for (int unsigned i = 0; i < BYTES; i++) begin
        if (wstrb_q[i]) mem[idx_q][i*8 +: 8] <= wdata_q[i*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_4_slave_mem.sv
// Scoreboard bench for axi_4_slave_mem: drivers push expected R/B beats,
// a negedge monitor pops and compares on every R or B handshake.
module tb_axi_4_slave_mem;
  import axi_4_pkg::*;

  localparam int unsigned DEPTH    = 1024;
  localparam int unsigned ADDR_LSB = 6;

  logic clk = 1'b0;
  logic reset;
  read_write_address_channel_t ar_ch, aw_ch;
  read_data_channel_t          r_ch;
  write_data_channel_t         w_ch;
  write_response_channel_t     b_ch;
  logic arvalid, arready, rvalid, rready, awvalid, awready;
  logic wvalid, wready, bvalid, bready;

  axi_4_slave_mem #(.DEPTH(DEPTH), .ADDR_LSB(ADDR_LSB)) dut (
    .clk(clk), .reset(reset),
    .ar_ch(ar_ch), .arvalid(arvalid), .arready(arready),
    .r_ch(r_ch), .rvalid(rvalid), .rready(rready),
    .aw_ch(aw_ch), .awvalid(awvalid), .awready(awready),
    .w_ch(w_ch), .wvalid(wvalid), .wready(wready),
    .b_ch(b_ch), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   id;
    logic [511:0] data;
    logic [1:0]   resp;
    logic         last;
  } r_exp_t;

  typedef struct {
    logic [3:0] id;
    logic [1:0] resp;
  } b_exp_t;

  r_exp_t r_q[$];
  b_exp_t b_q[$];
  logic [511:0] model [DEPTH];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got no response, required one within 50 cycles", name);
  endtask

  function automatic logic [511:0] pat(input logic [31:0] seed, input int k);
    return {16{seed + 32'(k)}};
  endfunction

  // Monitor: compare every completed R and B handshake against the scoreboard
  always @(negedge clk) begin
    if (!reset && rvalid && rready) begin
      if (r_q.size() == 0) begin
        timeout_fail("unexpected_r_beat");
      end else begin
        r_exp_t e;
        e = r_q.pop_front();
        check("rid", 512'(r_ch.rid), 512'(e.id));
        check("rdata", r_ch.rdata, e.data);
        check("rresp", 512'(r_ch.rresp), 512'(e.resp));
        check("rlast", 512'(r_ch.rlast), 512'(e.last));
      end
    end
    if (!reset && bvalid && bready) begin
      if (b_q.size() == 0) begin
        timeout_fail("unexpected_b_resp");
      end else begin
        b_exp_t e;
        e = b_q.pop_front();
        check("bid", 512'(b_ch.bid), 512'(e.id));
        check("bresp", 512'(b_ch.bresp), 512'(e.resp));
      end
    end
  end

  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int cnt = 0;
    ar_ch = '{axid: id, axaddr: addr, axlen: len, axsize: size, axburst: burst};
    arvalid = 1'b1;
    while (!arready && cnt < 50) begin @(posedge clk); #1; cnt++; end
    if (cnt >= 50) timeout_fail("arready_wait");
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic wait_aw();
    int cnt = 0;
    while (!awready && cnt < 50) begin @(posedge clk); #1; cnt++; end
    if (cnt >= 50) timeout_fail("awready_wait");
    @(posedge clk); #1;
    awvalid = 1'b0;
  endtask

  task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst);
    aw_ch = '{axid: id, axaddr: addr, axlen: len, axsize: 3'(ADDR_LSB), axburst: burst};
    awvalid = 1'b1;
    wait_aw();
  endtask

  task automatic send_w(input logic [511:0] data, input logic [63:0] strb, input logic last);
    int cnt = 0;
    w_ch = '{wid: 4'h0, wdata: data, wstrb: strb, wlast: last};
    wvalid = 1'b1;
    while (!wready && cnt < 50) begin @(posedge clk); #1; cnt++; end
    if (cnt >= 50) timeout_fail("wready_wait");
    @(posedge clk); #1;
    wvalid = 1'b0;
  endtask

  task automatic resp_b(input logic [3:0] id, input logic [1:0] resp, input int stall);
    int cnt = 0;
    b_q.push_back('{id: id, resp: resp});
    while (!bvalid && cnt < 50) begin @(posedge clk); #1; cnt++; end
    if (cnt >= 50) timeout_fail("bvalid_wait");
    repeat (stall) begin
      @(posedge clk); #1;
      check("bvalid_held", 512'(bvalid), 512'(1));
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic recv_r(input int nbeats, input int stall_beat, input int stall_cycles,
                        input int abort_beat);
    for (int b = 0; b < nbeats; b++) begin
      int cnt = 0;
      while (!rvalid && cnt < 50) begin @(posedge clk); #1; cnt++; end
      if (cnt >= 50) begin timeout_fail("rvalid_wait"); return; end
      if (b == abort_beat) begin
        reset = 1'b1;
        #1;
        check("abort_rvalid", 512'(rvalid), 512'(0));
        check("abort_arready", 512'(arready), 512'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("abort_idle_arready", 512'(arready), 512'(1));
        check("abort_idle_rvalid", 512'(rvalid), 512'(0));
        return;
      end
      if (b == stall_beat && r_q.size() > 0) begin
        repeat (stall_cycles) begin
          @(posedge clk); #1;
          check("stall_rvalid", 512'(rvalid), 512'(1));
          check("stall_rdata", r_ch.rdata, r_q[0].data);
          check("stall_rlast", 512'(r_ch.rlast), 512'(r_q[0].last));
        end
      end
      rready = 1'b1;
      @(posedge clk); #1;
      rready = 1'b0;
    end
  endtask

  task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input logic err,
                            input int stall_beat, input int stall_cycles, input int abort_beat);
    logic [9:0] li, line;
    int nb;
    r_exp_t e;
    li = addr[ADDR_LSB +: 10];
    nb = int'(len) + 1;
    if (abort_beat >= 0 && abort_beat < nb) nb = abort_beat;
    for (int k = 0; k < nb; k++) begin
      if (burst == BURST_WRAP)       line = (li & ~10'(len)) | ((li + 10'(k)) & 10'(len));
      else if (burst == BURST_FIXED) line = li;
      else                           line = li + 10'(k);
      e.id   = id;
      e.data = err ? '0 : model[line];
      e.resp = err ? RESP_SLVERR : RESP_OKAY;
      e.last = k == int'(len);
      r_q.push_back(e);
    end
    send_ar(id, addr, len, size, burst);
    check("r_latency_fetch", 512'(rvalid), 512'(0));
    @(posedge clk); #1;
    check("r_latency_valid", 512'(rvalid), 512'(1));
    recv_r(int'(len) + 1, stall_beat, stall_cycles, abort_beat);
  endtask

  task automatic write_single(input logic [3:0] id, input logic [31:0] addr,
                              input logic [511:0] data, input logic [63:0] strb,
                              input logic [1:0] resp);
    send_aw(id, addr, 8'd0, BURST_INCR);
    send_w(data, strb, 1'b1);
    resp_b(id, resp, 0);
  endtask

  task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [31:0] seed, input int nbeats, input logic [1:0] resp,
                             input int bstall);
    send_aw(id, addr, len, BURST_INCR);
    for (int k = 0; k < nbeats; k++) send_w(pat(seed, k), '1, k == nbeats - 1);
    resp_b(id, resp, bstall);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [511:0] strobe_exp;
    reset = 1'b1;
    ar_ch = '0; aw_ch = '0; w_ch = '0;
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0; rready = 1'b0; bready = 1'b0;
    #1;
    check("rst_arready", 512'(arready), 512'(0));
    check("rst_awready", 512'(awready), 512'(0));
    check("rst_wready", 512'(wready), 512'(0));
    check("rst_rvalid", 512'(rvalid), 512'(0));
    check("rst_bvalid", 512'(bvalid), 512'(0));
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdata", r_ch.rdata, '0);
    check("rst_rmeta", 512'({r_ch.rid, r_ch.rresp, r_ch.rlast}), '0);
    check("rst_b", 512'({b_ch.bid, b_ch.bresp}), '0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("idle_arready", 512'(arready), 512'(1));
    check("idle_awready", 512'(awready), 512'(1));
    check("idle_wready", 512'(wready), 512'(0));

    // Line 0 reference content
    write_single(4'h1, 32'h0, pat(32'hC0DE0000, 0), '1, RESP_OKAY);
    model[0] = pat(32'hC0DE0000, 0);

    // 4-beat INCR write at 0x40 with B backpressure, then read back with R backpressure
    write_burst(4'h3, 32'h40, 8'd3, 32'hA5A50000, 4, RESP_OKAY, 3);
    for (int k = 0; k < 4; k++) model[1 + k] = pat(32'hA5A50000, k);
    read_burst(4'h5, 32'h40, 8'd3, 3'(ADDR_LSB), BURST_INCR, 1'b0, 0, 5, -1);

    // WRAP over lines 2,3,0,1
    read_burst(4'h9, 32'h80, 8'd3, 3'(ADDR_LSB), BURST_WRAP, 1'b0, -1, 0, -1);

    // Strobe masking on line 5
    write_single(4'h2, 32'h140, '1, '1, RESP_OKAY);
    write_single(4'h2, 32'h140, '0, 64'h1, RESP_OKAY);
    strobe_exp = {{504{1'b1}}, 8'h00};
    model[5] = strobe_exp;
    read_burst(4'h4, 32'h140, 8'd0, 3'(ADDR_LSB), BURST_INCR, 1'b0, -1, 0, -1);

    // Simultaneous AR and AW: read first, then write to line 6
    ar_ch = '{axid: 4'h1, axaddr: 32'h40, axlen: 8'd0, axsize: 3'(ADDR_LSB), axburst: BURST_INCR};
    aw_ch = '{axid: 4'h2, axaddr: 32'h180, axlen: 8'd0, axsize: 3'(ADDR_LSB), axburst: BURST_INCR};
    arvalid = 1'b1;
    awvalid = 1'b1;
    #1;
    check("arb_arready", 512'(arready), 512'(1));
    check("arb_awready", 512'(awready), 512'(0));
    r_q.push_back('{id: 4'h1, data: model[1], resp: RESP_OKAY, last: 1'b1});
    @(posedge clk); #1;
    arvalid = 1'b0;
    check("arb_aw_blocked", 512'(awready), 512'(0));
    recv_r(1, -1, 0, -1);
    wait_aw();
    send_w(pat(32'h66660000, 0), '1, 1'b1);
    resp_b(4'h2, RESP_OKAY, 0);
    model[6] = pat(32'h66660000, 0);
    read_burst(4'h6, 32'h180, 8'd0, 3'(ADDR_LSB), BURST_INCR, 1'b0, -1, 0, -1);

    // Bad axsize read: two SLVERR beats of zero data
    read_burst(4'hA, 32'h80, 8'd1, 3'd3, BURST_INCR, 1'b1, -1, 0, -1);

    // Write beyond DEPTH: SLVERR and line 0 untouched
    write_single(4'hB, 32'(DEPTH) << ADDR_LSB, pat(32'hDEAD0000, 0), '1, RESP_SLVERR);
    read_burst(4'hC, 32'h0, 8'd0, 3'(ADDR_LSB), BURST_INCR, 1'b0, -1, 0, -1);

    // Early wlast: SLVERR but stored beats are kept
    write_burst(4'hD, 32'h200, 8'd3, 32'h88880000, 2, RESP_SLVERR, 0);
    model[8] = pat(32'h88880000, 0);
    model[9] = pat(32'h88880000, 1);
    read_burst(4'hE, 32'h200, 8'd1, 3'(ADDR_LSB), BURST_INCR, 1'b0, -1, 0, -1);

    // Reset during beat 2 of a 4-beat read, then a normal single read
    read_burst(4'h7, 32'h40, 8'd3, 3'(ADDR_LSB), BURST_INCR, 1'b0, -1, 0, 2);
    read_burst(4'h8, 32'h140, 8'd0, 3'(ADDR_LSB), BURST_INCR, 1'b0, -1, 0, -1);

    repeat (5) @(posedge clk);
    #1;
    check("r_queue_drained", 512'(r_q.size()), '0);
    check("b_queue_drained", 512'(b_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_4_slave_mem.md
Name: axi_4_slave_mem

Overview:
- Memory-backed AXI4 responder (slave) for the 512-bit vector/data bus; serves bursts issued by the AXI4 master side of the core.
- Holds a single-port line memory of DEPTH x DATA_BUS_WIDTH bits.
- Handles one transaction at a time, read or write, using the axi_4_slave_states_e FSM and the axi_4_pkg channel structs.
- Used as the memory model in system simulation and as the on-chip scratch memory.

Parameters:
- DEPTH, 1024, number of 512-bit lines (power of 2, >= 2).
- ADDR_LSB, 6, log2(DATA_BUS_WIDTH/8); byte-address bits below the line index.

Ports:
- clk  in  1  clock; rising edge.
- reset  in  1  asynchronous, active-high reset.
- ar_ch  in  read_write_address_channel_t  read address channel (arid, axaddr, axlen, axsize, axburst used).
- arvalid  in  1  read address valid.
- arready  out  1  read address ready.
- r_ch  out  read_data_channel_t  rid, rdata, rresp, rlast.
- rvalid  out  1  read data valid.
- rready  in  1  read data ready.
- aw_ch  in  read_write_address_channel_t  write address channel (awid, axaddr, axlen, axsize, axburst used).
- awvalid  in  1  write address valid.
- awready  out  1  write address ready.
- w_ch  in  write_data_channel_t  wdata, wstrb, wlast (wid ignored).
- wvalid  in  1  write data valid.
- wready  out  1  write data ready.
- b_ch  out  write_response_channel_t  bid, bresp.
- bvalid  in/out: out  1  write response valid.
- bready  in  1  write response ready.

Behaviour:
- Reset (async, active-high): state=SLAVE_IDLE; arready, awready, wready, rvalid and bvalid all 0; r_ch and b_ch 0; beat counter 0. Memory contents are not reset. Reset asserted mid-burst aborts the burst immediately with no response.
- SLAVE_IDLE: arready=1; awready=!arvalid; wready=0.
  - arvalid=1: capture arid, address line index=axaddr[ADDR_LSB+:log2(DEPTH)], axlen, burst, error flag; go to DATA_FETCH.
  - Else awvalid=1: capture the AW fields the same way; go to WAIT_WVALID.
  - Read wins over write when both are presented.
- DATA_FETCH (1 cycle): read the memory line; go to WAIT_RREADY.
- WAIT_RREADY: rvalid=1; rid=captured arid; rlast=(beat==axlen). Hold all of r_ch stable until rready.
  - On handshake with rlast=1: go to IDLE.
  - Otherwise: increment beat, advance the index, go to DATA_FETCH.
  - Latency: rvalid rises 2 cycles after each AR or R handshake.
- WAIT_WVALID: wready=1. On handshake, register wdata, wstrb and wlast, then go to DATA_STORE.
- DATA_STORE (1 cycle): write each byte lane i where wstrb[i]=1; other lanes are unchanged. Increment beat and advance the index.
  - wlast=1: go to WAIT_BREADY.
  - Else: go to WAIT_WVALID.
- WAIT_BREADY: bvalid=1; bid=captured awid; bresp held stable. On bready, go to IDLE.
- Address advance:
  - INCR (01): index+1 per beat, wrapping modulo DEPTH.
  - FIXED (00): index unchanged.
  - WRAP (10): wraps within an aligned (axlen+1)-line block; axlen must be 1, 3, 7 or 15.
- Responses are OKAY=2'b00 or SLVERR=2'b10. SLVERR is returned for any of:
  - axsize != ADDR_LSB
  - axburst == 2'b11
  - WRAP with an illegal axlen
  - line address beyond DEPTH (axaddr >> ADDR_LSB >= DEPTH)
- Read errors: every beat returns rresp=SLVERR and rdata=0, and all axlen+1 beats are still sent.
- Write errors: memory is not written for any beat of the burst.
- Write burst length: the burst ends on wlast. If the beat count != axlen+1, bresp=SLVERR, but the beats already stored are kept.
- Unused enum states (WAIT_ARVALID, WAIT_AWVALID_WVALID, WAIT_AWVALID): transition to SLAVE_IDLE.

Test Plan:
- Write then read: AW addr=0x40, axlen=3, INCR; 4 beats of data k, all strobes set -> bresp=00, bid=awid. Then AR with the same burst -> 4 beats, rdata=k, rlast only on beat 3, rresp=00.
- Strobe masking: line 5 preloaded 0xFF..FF; single-beat write of data 0 with wstrb=64'h1 -> a read of line 5 returns byte0=0x00 and all other bytes 0xFF.
- Backpressure: hold rready=0 for 5 cycles on beat 0 -> rvalid stays 1 and rdata/rlast stay stable. Hold bready=0 for 3 cycles -> bvalid stays 1.
- Arbitration: arvalid and awvalid asserted in the same idle cycle -> arready=1, awready=0. The read completes first, then the write is accepted.
- Errors:
  - axsize=3 read with axlen=1 -> 2 beats, rresp=10, rdata=0.
  - Write to line DEPTH -> bresp=10 and memory unchanged.
  - wlast on beat 1 of axlen=3 -> bresp=10.
- Reset mid-burst: assert reset during beat 2 of a 4-beat read -> rvalid=0 in the same cycle, state IDLE. A following single-beat read completes normally.
